// File: rtl/mult_pkg.sv
// Shared widths, sign-magnitude types and the in-flight tag record used by the
// multiplier-sharing arbiter.
package mult_pkg;

   localparam int WORD_W   = 32;
   localparam int PROD_W   = 64;
   localparam int SIGN_BIT = WORD_W - 1;
   // Wide enough for the largest supported requester count (8).
   localparam int ID_W     = 3;

   typedef logic [WORD_W-1:0] sm_word_t;
   typedef logic [PROD_W-1:0] sm_prod_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// wrapping from NUM_REQ-1 back to 0. The pointer register lives in the parent.
module rr_arbiter
   import mult_pkg::*;
#(
   parameter int NUM_REQ = 4
)
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   int cand;

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      cand      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && (i == cand) && req[i]) begin
               grant_any = 1'b1;
               grant[i]  = 1'b1;
               grant_id  = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one registered sign-magnitude multiplier among NUM_REQ requesters and
// steers each product back to its requester after LATENCY cycles.
module mult_share_arbiter
   import mult_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = 2
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*32-1:0]   req_a,
   input  logic [NUM_REQ*32-1:0]   req_b,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [63:0]             rsp_data,
   output logic [31:0]             mul_in1,
   output logic [31:0]             mul_in2,
   input  logic [63:0]             mul_out,
   output logic                    busy
);

   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] req_gated;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               grant_any;
   sm_word_t           op_a;
   sm_word_t           op_b;
   tag_t               tag_q [LATENCY];
   tag_t               tag_last;

   // Handshake: a transfer happens on slot i when req_valid[i] & req_ready[i]
   // in the same cycle. req_ready is one-hot, depends only on req_valid and
   // ptr, and is low whenever rst is high. Responses have no ready: rsp_valid
   // is a single-cycle strobe that the requester must take.
   assign req_gated = req_valid & {NUM_REQ{~rst}};

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req_gated),
      .ptr       (ptr),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            op_a = req_a[i*WORD_W +: WORD_W];
            op_b = req_b[i*WORD_W +: WORD_W];
         end
      end
   end

   assign mul_in1 = op_a;
   assign mul_in2 = op_b;

   // The tag pipe mirrors the multiplier's register stages so the id emerges
   // alongside its product; it never reorders.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
         for (int s = 0; s < LATENCY; s++) tag_q[s] <= '0;
      end else begin
         if (grant_any)
            ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         tag_q[0] <= '{valid: grant_any, id: grant_id};
         for (int s = 1; s < LATENCY; s++) tag_q[s] <= tag_q[s-1];
      end
   end

   assign tag_last = tag_q[LATENCY-1];

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (tag_last.valid && (tag_last.id == ID_W'(i))) rsp_valid[i] = 1'b1;
      end
   end

   assign rsp_data = mul_out;

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < LATENCY; s++) busy = busy | tag_q[s].valid;
   end

endmodule
